ucie_ctl_tx_rdi_launcher: RTL

Transmit-side launcher that sits directly upstream of the physical-layer RDI data path. It accepts flit chunks from the adapter's FDI side and buffers them in a small FIFO. It launches the chunks onto the RDI lp_valid/lp_irdy/lp_data lanes under the pl_trdy handshake, and gates transmission on the physical layer's reported RDI state. It is the TX counterpart feeding the PHY, whose received output is consumed by the RX top.

---
 rtl/ucie_ctl_tx_pkg.sv | 21 ++
 rtl/ucie_ctl_tx_sync_fifo.sv | 66 ++++++
 rtl/ucie_ctl_tx_rdi_launcher.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ucie_ctl_tx_pkg.sv
// Shared definitions for the UCIe TX RDI launcher: RDI state codes, launcher FSM
// states and the transfer counter ceiling.
package ucie_ctl_tx_pkg;

    localparam logic [3:0] RDI_RESET     = 4'b0000;
    localparam logic [3:0] RDI_ACTIVE    = 4'b0001;
    localparam logic [3:0] RDI_LINKRESET = 4'b1001;
    localparam logic [3:0] RDI_LINKERROR = 4'b1010;
    localparam logic [3:0] RDI_RETRAIN   = 4'b1011;
    localparam logic [3:0] RDI_DISABLED  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2,
        FLUSH  = 2'd3
    } tx_state_e;

    localparam logic [31:0] TX_COUNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/ucie_ctl_tx_sync_fifo.sv
// Synchronous FIFO with flush; flush takes priority over push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module ucie_ctl_tx_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == LW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_level = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            if (w_push && !w_pop) begin
                r_count <= r_count + LW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - LW'(1);
            end
        end
    end

endmodule

// File: rtl/ucie_ctl_tx_rdi_launcher.sv
// TX launcher: buffers FDI chunks and launches them on RDI, gated by pl_state_sts.
// Define UCIE_CTL_TX_STATS_EN to enable the saturating o_tx_count transfer counter.
module ucie_ctl_tx_rdi_launcher
    import ucie_ctl_tx_pkg::*;
#(
    parameter int NBYTES = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NBYTES*8-1:0]        i_fdi_lp_data,
    input  logic                       i_fdi_lp_valid,
    output logic                       o_fdi_pl_trdy,
    input  logic [3:0]                 i_rdi_pl_state_sts,
    input  logic                       i_rdi_pl_trdy,
    output logic                       o_rdi_lp_valid,
    output logic                       o_rdi_lp_irdy,
    output logic [NBYTES*8-1:0]        o_rdi_lp_data,
    output logic [$clog2(DEPTH+1)-1:0] o_fifo_level,
    output logic                       o_data_dropped,
    output logic [31:0]                o_tx_count
);
    localparam int W  = NBYTES * 8;
    localparam int LW = $clog2(DEPTH+1);

    tx_state_e        r_state;
    tx_state_e        w_next;
    logic             r_dropped;
    logic             w_full;
    logic             w_empty;
    logic [LW-1:0]    w_level;
    logic [W-1:0]     w_head;
    logic             w_trdy;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic             w_keep;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_rdi_pl_state_sts == RDI_ACTIVE) w_next = ACTIVE;
            end
            ACTIVE, STALL: begin
                if (i_rdi_pl_state_sts == RDI_ACTIVE)       w_next = ACTIVE;
                else if (i_rdi_pl_state_sts == RDI_RETRAIN) w_next = STALL;
                else                                        w_next = FLUSH;
            end
            FLUSH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshakes depend only on registered state and FIFO occupancy.
    assign w_trdy  = ((r_state == ACTIVE) || (r_state == STALL)) && !w_full;
    assign w_valid = (r_state == ACTIVE) && !w_empty;
    assign w_push  = i_fdi_lp_valid && w_trdy;
    assign w_pop   = w_valid && i_rdi_pl_trdy;

    // The FIFO is cleared on the edge entering FLUSH, so FLUSH already shows level 0.
    assign w_flush = (w_next == FLUSH);
    assign w_keep  = w_push || (w_pop ? (w_level > LW'(1)) : (w_level != '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_flush && w_keep;
        end
    end

    ucie_ctl_tx_sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (i_fdi_lp_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign o_fdi_pl_trdy  = w_trdy;
    assign o_rdi_lp_valid = w_valid;
    assign o_rdi_lp_irdy  = w_valid;
    assign o_rdi_lp_data  = w_valid ? w_head : '0;
    assign o_fifo_level   = w_level;
    assign o_data_dropped = r_dropped;

`ifdef UCIE_CTL_TX_STATS_EN
    logic [31:0] r_tx_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_count <= '0;
        end else if (w_pop && (r_tx_count != TX_COUNT_MAX)) begin
            r_tx_count <= r_tx_count + 32'd1;
        end
    end

    assign o_tx_count = r_tx_count;
`else
    assign o_tx_count = '0;
`endif

endmodule
